avmm_rr_arbiter: RTL

//   Shares one Avalon-MM read/write master port between NUM_REQ HLS component instances.

---
 rtl/avmm_rr_arbiter_pkg.sv | 19 +
 rtl/avmm_rr_arbiter_if.sv | 41 ++++
 rtl/avmm_rr_arbiter_rr_arbiter.sv | 36 +++
 rtl/avmm_rr_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/avmm_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin Avalon-MM arbiter.
// Requester ids are sized for the largest supported requester count (16).
package avmm_arb_pkg;
   localparam int MAX_REQ = 16;
   localparam int ID_W    = $clog2(MAX_REQ);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } rd_tag_t;

   function automatic logic [ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++)
         if (oh[i]) idx = idx | ID_W'(i);
      return idx;
   endfunction
endpackage

// File: rtl/avmm_rr_arbiter_if.sv
// Requester-side and master-side bus bundle of the arbiter.
// master = arbiter view, slave = requesters plus downstream memory.
interface avmm_rr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64
);
   localparam int BE_W = DATA_W / 8;

   logic [NUM_REQ-1:0][ADDR_W-1:0] req_address;
   logic [NUM_REQ-1:0][BE_W-1:0]   req_byteenable;
   logic [NUM_REQ-1:0]             req_read;
   logic [NUM_REQ-1:0]             req_write;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
   logic [NUM_REQ-1:0]             req_waitrequest;
   logic [DATA_W-1:0]              req_readdata;
   logic [NUM_REQ-1:0]             req_readdatavalid;

   logic [ADDR_W-1:0]              avmm_0_rw_address;
   logic [BE_W-1:0]                avmm_0_rw_byteenable;
   logic                           avmm_0_rw_read;
   logic                           avmm_0_rw_write;
   logic [DATA_W-1:0]              avmm_0_rw_writedata;
   logic [DATA_W-1:0]              avmm_0_rw_readdata;

   modport master (
      input  req_address, req_byteenable, req_read, req_write, req_writedata,
             avmm_0_rw_readdata,
      output req_waitrequest, req_readdata, req_readdatavalid,
             avmm_0_rw_address, avmm_0_rw_byteenable, avmm_0_rw_read,
             avmm_0_rw_write, avmm_0_rw_writedata
   );

   modport slave (
      output req_address, req_byteenable, req_read, req_write, req_writedata,
             avmm_0_rw_readdata,
      input  req_waitrequest, req_readdata, req_readdatavalid,
             avmm_0_rw_address, avmm_0_rw_byteenable, avmm_0_rw_read,
             avmm_0_rw_write, avmm_0_rw_writedata
   );
endinterface

// File: rtl/avmm_rr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts just above ptr_i and wraps.
// The caller owns the pointer register.
module rr_arbiter
   import avmm_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    winner_o,
   output logic               any_grant_o
);
   logic found;

   // First pass covers indices above the pointer, second pass the wrap-around.
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_i[i] && (ID_W'(i) > ptr_i)) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_i[i]) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign winner_o    = onehot_to_idx(MAX_REQ'(grant_o));
   assign any_grant_o = found;
endmodule

// File: rtl/avmm_rr_arbiter.sv
// Shares one Avalon-MM rw master among NUM_REQ requesters, round-robin,
// registered command outputs, fixed-latency read return routed by a tag pipe.
module avmm_rr_arbiter
   import avmm_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int READ_LATENCY = 2
) (
   input  logic               clock,
   input  logic               reset,
   avmm_rr_arbiter_if.master  bus,
   output logic               arb_error
);
   localparam int BE_W = DATA_W / 8;

   logic [NUM_REQ-1:0] active, grant;
   logic [ID_W-1:0]    winner;
   logic               any_grant;

   logic [ADDR_W-1:0]  mux_addr;
   logic [BE_W-1:0]    mux_be;
   logic [DATA_W-1:0]  mux_wdata;
   logic               mux_read, mux_write;

   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [BE_W-1:0]    be_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               read_q, write_q;
   logic               err_q, err_d;
   rd_tag_t            tag_d;
   rd_tag_t [READ_LATENCY:0] tag_q;

   assign active = bus.req_read | bus.req_write;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i       (active),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .winner_o    (winner),
      .any_grant_o (any_grant)
   );

   always_comb begin
      mux_addr  = '0;
      mux_be    = '0;
      mux_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            mux_addr  = bus.req_address[i];
            mux_be    = bus.req_byteenable[i];
            mux_wdata = bus.req_writedata[i];
         end
      end
   end

   // read & write together is illegal; the read wins.
   assign mux_read  = |(grant & bus.req_read);
   assign mux_write = |(grant & bus.req_write) & ~mux_read;

   assign ptr_d     = any_grant ? winner : ptr_q;
   assign err_d     = err_q | (|(bus.req_read & bus.req_write));
   assign tag_d     = '{valid: any_grant & mux_read, id: winner};

   assign bus.req_waitrequest = reset ? '0 : (active & ~grant);

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q   <= ID_W'(NUM_REQ - 1);
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         tag_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         read_q  <= any_grant & mux_read;
         write_q <= any_grant & mux_write;
         err_q   <= err_d;
         if (any_grant) begin
            addr_q  <= mux_addr;
            be_q    <= mux_be;
            wdata_q <= mux_wdata;
         end
         // Entry k is visible k+1 cycles after the grant; the last one lines up with readdata.
         tag_q[0] <= tag_d;
         for (int k = 1; k <= READ_LATENCY; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   always_comb begin
      bus.req_readdatavalid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         bus.req_readdatavalid[i] = tag_q[READ_LATENCY].valid &&
                                    (tag_q[READ_LATENCY].id == ID_W'(i));
   end

   assign bus.req_readdata         = tag_q[READ_LATENCY].valid ? bus.avmm_0_rw_readdata : '0;
   assign bus.avmm_0_rw_address    = addr_q;
   assign bus.avmm_0_rw_byteenable = be_q;
   assign bus.avmm_0_rw_read       = read_q;
   assign bus.avmm_0_rw_write      = write_q;
   assign bus.avmm_0_rw_writedata  = wdata_q;
   assign arb_error                = err_q;
endmodule
